// File: rtl/regfile_scoreboard.sv
// Parametrised MIPS register file with write-to-read bypass and a per-register
// pending-write scoreboard for RAW/WAW hazard detection.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned DBG_REG  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_count,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic        HAS_ZERO = (ZERO_REG != 0);
  localparam logic        HAS_BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic wr_drop;
  logic wr_hits_issue;
  logic issue_zero;
  logic issue_accept;

  // Hazard checks on the issue and write destinations.
  always_comb begin
    wr_drop       = HAS_ZERO && (wr_addr == '0);
    wr_hits_issue = wr_en && (wr_addr == issue_addr);
    issue_zero    = HAS_ZERO && (issue_addr == '0);
    issue_ready   = !busy_q[issue_addr] || wr_hits_issue || issue_zero;
    issue_accept  = issue_en && issue_ready && !issue_zero && !flush;
  end

  // Next busy vector: flush wins; a same-edge issue keeps ownership over a retiring write.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) busy_d[wr_addr] = 1'b0;
      if (issue_accept) busy_d[issue_addr] = 1'b1;
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en && !wr_drop) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    always_comb begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if (HAS_ZERO && (a == '0)) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
        rd_busy[p]                  = 1'b0;
      end else if (HAS_BYP && wr_en && (wr_addr == a)) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
        rd_busy[p]                  = 1'b0;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = regs[a];
        rd_busy[p]                  = busy_q[a];
      end
    end
  end

  assign busy_count = count_q;
  assign dbg_data   = regs[ADDR_W'(DBG_REG)];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard: reset, writes, zero register, bypass,
// scoreboard hazards, flush and asynchronous reset.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        flush;
  logic [5:0]  busy_count;
  logic [31:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .flush(flush), .busy_count(busy_count), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rd(5'd5, 5'd2);
    #3;
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_busy", 64'(rd_busy), 64'h0);
    chk("rst_busy_count", 64'(busy_count), 64'h0);
    chk("rst_dbg", 64'(dbg_data), 64'h0);
    chk("rst_issue_ready", 64'(issue_ready), 64'h1);

    // Release reset and write r5 on the first edge.
    at_neg();
    reset = 1'b1;
    wr(5'd5, 32'hDEADBEEF);
    at_neg();
    idle();
    rd(5'd0, 5'd5);
    #1;
    chk("r5_port1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    chk("r5_busy", 64'(rd_busy[1]), 64'h0);

    // Zero register ignores writes and issues.
    at_neg();
    wr(5'd0, 32'h1234);
    iss(5'd0);
    #1;
    chk("r0_issue_ready", 64'(issue_ready), 64'h1);
    at_neg();
    idle();
    rd(5'd0, 5'd0);
    #1;
    chk("r0_read", 64'(rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(rd_busy[0]), 64'h0);
    chk("r0_busy_count", 64'(busy_count), 64'h0);

    // Same-cycle bypass on both ports.
    at_neg();
    wr(5'd7, 32'hA5A5A5A5);
    rd(5'd7, 5'd7);
    #1;
    chk("byp_port0", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    chk("byp_port1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    chk("byp_busy", 64'(rd_busy), 64'h0);
    at_neg();
    idle();
    #1;
    chk("r7_stored", 64'(rd_data[31:0]), 64'hA5A5A5A5);

    // Scoreboard: issue r3, then WAW stall.
    at_neg();
    iss(5'd3);
    #1;
    chk("iss_r3_ready", 64'(issue_ready), 64'h1);
    at_neg();
    idle();
    rd(5'd3, 5'd4);
    iss(5'd3);
    #1;
    chk("r3_count1", 64'(busy_count), 64'h1);
    chk("r3_rd_busy", 64'(rd_busy[0]), 64'h1);
    chk("r3_waw_stall", 64'(issue_ready), 64'h0);
    at_neg();
    #1;
    chk("r3_stall_count", 64'(busy_count), 64'h1);

    // Retire r3 while re-issuing it: ownership passes to the new instruction.
    wr(5'd3, 32'h33);
    #1;
    chk("r3_reissue_ready", 64'(issue_ready), 64'h1);
    chk("r3_reissue_byp", 64'(rd_data[31:0]), 64'h33);
    at_neg();
    idle();
    #1;
    chk("r3_still_busy", 64'(rd_busy[0]), 64'h1);
    chk("r3_count_keep", 64'(busy_count), 64'h1);
    chk("r3_data", 64'(rd_data[31:0]), 64'h33);
    wr(5'd3, 32'h44);
    at_neg();
    idle();
    #1;
    chk("r3_retired_count", 64'(busy_count), 64'h0);
    chk("r3_retired_busy", 64'(rd_busy[0]), 64'h0);
    chk("r3_retired_data", 64'(rd_data[31:0]), 64'h44);

    // Flush with a concurrent issue (dropped) and write (kept).
    iss(5'd1);
    at_neg();
    iss(5'd2);
    at_neg();
    iss(5'd4);
    at_neg();
    idle();
    #1;
    chk("pre_flush_count", 64'(busy_count), 64'h3);
    flush = 1'b1;
    iss(5'd6);
    wr(5'd2, 32'h55);
    at_neg();
    idle();
    rd(5'd6, 5'd2);
    #1;
    chk("flush_count", 64'(busy_count), 64'h0);
    chk("flush_r6_busy", 64'(rd_busy[0]), 64'h0);
    chk("flush_r2_busy", 64'(rd_busy[1]), 64'h0);
    chk("flush_r2_data", 64'(rd_data[63:32]), 64'h55);
    chk("flush_dbg", 64'(dbg_data), 64'h55);

    // Asynchronous reset between edges.
    wr(5'd2, 32'h9);
    iss(5'd8);
    at_neg();
    idle();
    rd(5'd8, 5'd2);
    issue_addr = 5'd8;
    #1;
    chk("pre_rst_dbg", 64'(dbg_data), 64'h9);
    chk("pre_rst_count", 64'(busy_count), 64'h1);
    chk("pre_rst_ready", 64'(issue_ready), 64'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_dbg", 64'(dbg_data), 64'h0);
    chk("arst_count", 64'(busy_count), 64'h0);
    chk("arst_ready", 64'(issue_ready), 64'h1);
    chk("arst_rd", {62'h0, rd_busy} | 64'(rd_data[31:0]), 64'h0);

    // Writes and issues are ignored while reset is held.
    wr(5'd2, 32'h77);
    iss(5'd9);
    at_neg();
    #1;
    chk("rst_hold_dbg", 64'(dbg_data), 64'h0);
    chk("rst_hold_count", 64'(busy_count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
